// File: rtl/free_index_allocator_pkg.sv
// Shared packet-table types and helpers for the free-index allocator.
// Holds the default entry-table depth and a width-agnostic popcount.
package free_index_allocator_pkg;

    // Default depth of the packet controller's entry table.
    localparam int PKT_TABLE_ENTRIES = 8;

    // Widest bitmap popcount() accepts; narrower vectors are zero-extended.
    localparam int POPCOUNT_MAX_W = 256;

    // Number of set bits in vec.
    function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
            n += 32'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/free_index_allocator_next_free_index_comb.sv
// next_free_index_comb: combinational highest-set-bit picker over a
// free-slot bitmap. found is the OR of the bitmap; index is 0 when empty.
module next_free_index_comb #(
    parameter  int NUM_ENTRIES = 8,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] bitmap,
    output logic                   found,
    output logic [IDX_W-1:0]       index
);

    // Scan upward so the highest set bit is the last one written.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (bitmap[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/free_index_allocator.sv
// free_index_allocator: owns the free-slot bitmap of the packet entry table.
// Offers the highest free index over valid/ready, accepts NUM_FREE_PORTS
// returns per cycle and reports a registered free count.
// Optional: define FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN to add the
// sticky double_free_err flag.
module free_index_allocator
    import free_index_allocator_pkg::*;
#(
    parameter  int NUM_ENTRIES    = PKT_TABLE_ENTRIES,
    parameter  int NUM_FREE_PORTS = 2,
    localparam int IDX_W          = $clog2(NUM_ENTRIES),
    localparam int CNT_W          = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              alloc_valid,
    input  logic                              alloc_ready,
    output logic [IDX_W-1:0]                  alloc_index,
    input  logic [NUM_FREE_PORTS-1:0]         free_valid,
    input  logic [NUM_FREE_PORTS*IDX_W-1:0]   free_index,
    output logic [CNT_W-1:0]                  free_count,
`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    output logic                              double_free_err,
`endif
    output logic                              all_free
);

    typedef logic [IDX_W-1:0] alloc_idx_t;

    logic [NUM_ENTRIES-1:0]    free_bitmap;
    logic [NUM_ENTRIES-1:0]    bitmap_next;
    logic [POPCOUNT_MAX_W-1:0] bitmap_next_ext;
    alloc_idx_t                pick_index;
    logic                      pick_found;

    next_free_index_comb #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_pick (
        .bitmap (free_bitmap),
        .found  (pick_found),
        .index  (pick_index)
    );

    assign alloc_valid = pick_found;
    assign alloc_index = pick_index;
    assign all_free    = (free_count == CNT_W'(NUM_ENTRIES));

    // Next bitmap: clear the granted bit, then apply returns so a free of
    // the index being granted this cycle leaves it set.
    always_comb begin
        bitmap_next = free_bitmap;
        if (alloc_valid && alloc_ready) begin
            bitmap_next[alloc_index] = 1'b0;
        end
        for (int p = 0; p < NUM_FREE_PORTS; p++) begin
            if (free_valid[p] && (int'(free_index[p*IDX_W +: IDX_W]) < NUM_ENTRIES)) begin
                bitmap_next[free_index[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        bitmap_next_ext                  = '0;
        bitmap_next_ext[NUM_ENTRIES-1:0] = bitmap_next;
    end

    // Register the bitmap and its popcount; reset marks every entry free.
    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_bitmap <= '1;
            free_count  <= CNT_W'(NUM_ENTRIES);
        end else begin
            free_bitmap <= bitmap_next;
            free_count  <= CNT_W'(popcount(bitmap_next_ext));
        end
    end

`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    logic double_free_hit;

    // Flag a return of an already-free entry, or two ports returning the
    // same entry in one cycle; judged against the pre-edge bitmap.
    always_comb begin
        double_free_hit = 1'b0;
        for (int p = 0; p < NUM_FREE_PORTS; p++) begin
            if (free_valid[p] && (int'(free_index[p*IDX_W +: IDX_W]) < NUM_ENTRIES)) begin
                if (free_bitmap[free_index[p*IDX_W +: IDX_W]]) begin
                    double_free_hit = 1'b1;
                end
                for (int q = 0; q < p; q++) begin
                    if (free_valid[q] &&
                        (free_index[q*IDX_W +: IDX_W] == free_index[p*IDX_W +: IDX_W])) begin
                        double_free_hit = 1'b1;
                    end
                end
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            double_free_err <= 1'b0;
        end else if (double_free_hit) begin
            double_free_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_free_index_allocator.sv
// Testbench for free_index_allocator (NUM_ENTRIES = 8, NUM_FREE_PORTS = 2).
// A set-of-free-entries model tracks the expected state; a negedge compare
// process checks every cycle, and directed scenarios pin literal values.
// Honours FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN like the design.
module tb_free_index_allocator;

    localparam int NE = 8;
    localparam int NP = 2;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_valid;
    logic          alloc_ready = 1'b0;
    logic [IW-1:0] alloc_index;
    logic [NP-1:0] free_valid = '0;
    logic [NP*IW-1:0] free_index = '0;
    logic [CW-1:0] free_count;
    logic          all_free;
`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    logic          double_free_err;
`endif

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    // Model: which entries are free, plus the sticky error.
    bit m_free [NE];
    bit m_err;

    free_index_allocator #(
        .NUM_ENTRIES    (NE),
        .NUM_FREE_PORTS (NP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_index     (alloc_index),
        .free_valid      (free_valid),
        .free_index      (free_index),
        .free_count      (free_count),
`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
        .double_free_err (double_free_err),
`endif
        .all_free        (all_free)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NE; i++) n += int'(m_free[i]);
        return n;
    endfunction

    function automatic int m_highest();
        int h = 0;
        for (int i = 0; i < NE; i++) if (m_free[i]) h = i;
        return h;
    endfunction

    // Model update from the rules: grant uses pre-edge state, frees win.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NE; i++) m_free[i] = 1'b1;
            m_err = 1'b0;
        end else begin
            bit nxt [NE];
            int idx [NP];
            nxt = m_free;
            if (alloc_ready && m_count() > 0) nxt[m_highest()] = 1'b0;
            for (int p = 0; p < NP; p++) begin
                idx[p] = int'(free_index[p*IW +: IW]);
                if (free_valid[p]) begin
                    if (m_free[idx[p]]) m_err = 1'b1;
                    for (int q = 0; q < p; q++)
                        if (free_valid[q] && idx[q] == idx[p]) m_err = 1'b1;
                    nxt[idx[p]] = 1'b1;
                end
            end
            m_free = nxt;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_on && !rst) begin
            check("alloc_valid", int'(alloc_valid), int'(m_count() > 0));
            check("alloc_index", int'(alloc_index), m_highest());
            check("free_count", int'(free_count), m_count());
            check("all_free", int'(all_free), int'(m_count() == NE));
`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
            check("double_free_err", int'(double_free_err), int'(m_err));
`endif
        end
    end

    // Apply inputs for one clock edge, return at the following negedge.
    task automatic cycle(input bit rdy, input bit v0, input int i0, input bit v1, input int i1);
        alloc_ready = rdy;
        free_valid  = {v1, v0};
        free_index  = {IW'(i1), IW'(i0)};
        @(negedge clk);
        alloc_ready = 1'b0;
        free_valid  = '0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset release with alloc_ready low.
        #12;
        rst = 1'b0;
        model_on = 1'b1;
        @(negedge clk);
        check("rst_valid", int'(alloc_valid), 1);
        check("rst_index", int'(alloc_index), 7);
        check("rst_count", int'(free_count), 8);
        check("rst_all_free", int'(all_free), 1);
`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
        check("rst_err", int'(double_free_err), 0);
`endif

        // Drain: grants 7 down to 0 on consecutive edges.
        for (int i = 0; i < NE; i++) begin
            check("drain_index", int'(alloc_index), 7 - i);
            cycle(1'b1, 1'b0, 0, 1'b0, 0);
        end
        check("empty_valid", int'(alloc_valid), 0);
        check("empty_count", int'(free_count), 0);
        check("empty_index", int'(alloc_index), 0);

        // Two returns in one cycle while empty.
        cycle(1'b0, 1'b1, 3, 1'b1, 5);
        check("ret_count", int'(free_count), 2);
        check("ret_index", int'(alloc_index), 5);
        cycle(1'b1, 1'b0, 0, 1'b0, 0);
        check("ret_next_index", int'(alloc_index), 3);

        // Grant 3 while returning 0 leaves only entry 0 free.
        cycle(1'b1, 1'b1, 0, 1'b0, 0);
        check("one_count", int'(free_count), 1);
        check("one_index", int'(alloc_index), 0);
        // Grant and free of entry 0 together: the free wins.
        cycle(1'b1, 1'b1, 0, 1'b0, 0);
        check("collide_count", int'(free_count), 1);
        check("collide_valid", int'(alloc_valid), 1);
        check("collide_index", int'(alloc_index), 0);

        // Duplicate return on both ports sets the bit once.
        cycle(1'b0, 1'b1, 6, 1'b1, 6);
        check("dup_count", int'(free_count), 2);
        check("dup_index", int'(alloc_index), 6);

`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
        // Returning an already-free entry raises the sticky flag.
        reset_pulse();
        cycle(1'b0, 1'b1, 2, 1'b0, 0);
        check("dfree_set", int'(double_free_err), 1);
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0, 0);
        check("dfree_sticky", int'(double_free_err), 1);
`endif

        // Asynchronous reset with three entries allocated.
        reset_pulse();
        repeat (3) cycle(1'b1, 1'b0, 0, 1'b0, 0);
        check("pre_areset_count", int'(free_count), 5);
        #2;
        rst = 1'b1;
        #1;
        check("areset_valid", int'(alloc_valid), 1);
        check("areset_index", int'(alloc_index), 7);
        check("areset_count", int'(free_count), 8);
        check("areset_all_free", int'(all_free), 1);
`ifdef FREE_INDEX_ALLOCATOR_DOUBLE_FREE_CHECK_EN
        check("areset_err", int'(double_free_err), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, NE - 1)),
                  ($urandom_range(0, 2) == 0), int'($urandom_range(0, NE - 1)));
            if (n == 1500) reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
